// File: rtl/serial_deshift_if.sv
// Serial receive link plus parallel word output with valid/ready handshake.
interface serial_deshift_if #(parameter int n = 16);
  localparam int CW = $clog2(n);

  logic          ser_in;
  logic          ser_valid;
  logic          dir;
  logic          clear;
  logic          out_ready;
  logic [n-1:0]  data_out;
  logic          out_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;

  modport master (
    output ser_in, ser_valid, dir, clear, out_ready,
    input  data_out, out_valid, busy, bit_cnt, overrun
  );

  modport slave (
    input  ser_in, ser_valid, dir, clear, out_ready,
    output data_out, out_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/serial_deshift.sv
// Serial-to-parallel receiver: assembles n serial bits (MSB- or LSB-first)
// into a word held in a single-entry output register with valid/ready.
module serial_deshift #(
  parameter int n = 16
) (
  input logic       clk,
  input logic       reset,
  serial_deshift_if.slave bus
);
  localparam int CW = $clog2(n);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state;
  logic [n-1:0]  sr;
  logic [n-1:0]  next_sr;
  logic [CW-1:0] bit_cnt;
  logic          dir_lat;
  logic          cur_dir;
  logic [n-1:0]  data_out;
  logic          out_valid;
  logic          overrun;
  logic          last_bit;
  logic          can_load;

  // The first bit of a word follows the live dir; later bits the latched one.
  always_comb begin
    cur_dir  = (state == IDLE) ? bus.dir : dir_lat;
    next_sr  = cur_dir ? {bus.ser_in, sr[n-1:1]} : {sr[n-2:0], bus.ser_in};
    last_bit = (bit_cnt == CW'(n-1));
    can_load = !out_valid || bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      dir_lat   <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (out_valid && bus.out_ready)
        out_valid <= 1'b0;

      if (bus.clear) begin
        state   <= IDLE;
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (bus.ser_valid) begin
        sr <= next_sr;
        if (state == IDLE)
          dir_lat <= bus.dir;
        if (last_bit) begin
          state   <= IDLE;
          bit_cnt <= '0;
          // A word finishing into a full, unconsumed holding register is lost.
          if (can_load) begin
            data_out  <= next_sr;
            out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          state   <= RECV;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = data_out;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state == RECV);
  assign bus.bit_cnt   = bit_cnt;
  assign bus.overrun   = overrun;
endmodule

// File: tb/tb_serial_deshift.sv
// Directed bench for serial_deshift: word assembly in both bit orders,
// gaps, handshake, overrun, clear and mid-word reset.
module tb_serial_deshift;
  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  serial_deshift_if #(.n(16)) bus ();
  serial_deshift #(.n(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends the top nbits of w, first bit = w[15]. dir starts at d0 and is
  // inverted from bit index flip_at onward; gaps inserts idle cycles between bits.
  task automatic send(input logic [15:0] w, input int nbits, input logic d0,
                      input int flip_at, input bit gaps);
    for (int k = 0; k < nbits; k++) begin
      bus.dir       = (k >= flip_at) ? ~d0 : d0;
      bus.ser_in    = w[15-k];
      bus.ser_valid = 1'b1;
      step();
      if (gaps && k < nbits - 1) begin
        bus.ser_valid = 1'b0;
        bus.ser_in    = ~bus.ser_in;
        step();
      end
    end
    bus.ser_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.dir       = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_data",    32'(bus.data_out),  32'h0);
    chk("rst_busy",    32'(bus.busy),      32'd0);
    chk("rst_cnt",     32'(bus.bit_cnt),   32'd0);
    chk("rst_overrun", 32'(bus.overrun),   32'd0);

    // MSB-first word
    send(16'hA5C3, 16, 1'b0, 99, 1'b0);
    chk("msb_valid", 32'(bus.out_valid), 32'd1);
    chk("msb_data",  32'(bus.data_out),  32'hA5C3);
    chk("msb_busy",  32'(bus.busy),      32'd0);
    chk("msb_cnt",   32'(bus.bit_cnt),   32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("msb_consumed", 32'(bus.out_valid), 32'd0);

    // LSB-first, dir flips mid-word but the latched value rules
    send(16'hA5C3, 16, 1'b1, 3, 1'b0);
    chk("lsb_valid", 32'(bus.out_valid), 32'd1);
    chk("lsb_data",  32'(bus.data_out),  32'hC3A5);
    bus.out_ready = 1'b1;
    step();
    chk("lsb_consumed", 32'(bus.out_valid), 32'd0);

    // Gapped stream, out_ready held high: one-cycle valid pulse
    send(16'h1234, 16, 1'b0, 99, 1'b1);
    chk("gap_valid", 32'(bus.out_valid), 32'd1);
    chk("gap_data",  32'(bus.data_out),  32'h1234);
    step();
    chk("gap_pulse", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Overrun: second word dropped while first is unconsumed
    send(16'h00FF, 16, 1'b0, 99, 1'b0);
    chk("ovr_first",    32'(bus.data_out), 32'h00FF);
    chk("ovr_none_yet", 32'(bus.overrun),  32'd0);
    send(16'hFF00, 16, 1'b0, 99, 1'b0);
    chk("ovr_data_kept", 32'(bus.data_out),  32'h00FF);
    chk("ovr_valid",     32'(bus.out_valid), 32'd1);
    chk("ovr_flag",      32'(bus.overrun),   32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("ovr_xfer_valid", 32'(bus.out_valid), 32'd0);
    chk("ovr_xfer_data",  32'(bus.data_out),  32'h00FF);
    chk("ovr_sticky",     32'(bus.overrun),   32'd1);
    step();
    chk("ovr_still", 32'(bus.overrun), 32'd1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Partial word aborted by clear together with a valid bit
    send(16'hFFFF, 7, 1'b0, 99, 1'b0);
    chk("part_cnt",  32'(bus.bit_cnt), 32'd7);
    chk("part_busy", 32'(bus.busy),    32'd1);
    bus.clear     = 1'b1;
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b1;
    step();
    bus.clear     = 1'b0;
    bus.ser_valid = 1'b0;
    chk("clr_cnt",   32'(bus.bit_cnt),   32'd0);
    chk("clr_busy",  32'(bus.busy),      32'd0);
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    send(16'hBEEF, 15, 1'b0, 99, 1'b0);
    chk("beef_cnt15", 32'(bus.bit_cnt), 32'd15);
    bus.ser_in    = 1'b1;
    bus.ser_valid = 1'b1;
    step();
    bus.ser_valid = 1'b0;
    chk("beef_data",  32'(bus.data_out),  32'hBEEF);
    chk("beef_valid", 32'(bus.out_valid), 32'd1);
    chk("beef_cnt",   32'(bus.bit_cnt),   32'd0);

    // Reset mid-word while a word is held
    send(16'h5555, 9, 1'b0, 99, 1'b0);
    chk("pre_rst_cnt",   32'(bus.bit_cnt),   32'd9);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset         = 1'b1;
    bus.ser_valid = 1'b1;
    step();
    reset         = 1'b0;
    bus.ser_valid = 1'b0;
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_data",  32'(bus.data_out),  32'h0);
    chk("mrst_cnt",   32'(bus.bit_cnt),   32'd0);
    chk("mrst_busy",  32'(bus.busy),      32'd0);
    send(16'h8001, 16, 1'b0, 99, 1'b0);
    chk("post_rst_data",  32'(bus.data_out),  32'h8001);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
